// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data memory) arbiter onto a single MFA/MFC RAM port.
// Round-robin on ties, alignment checking at grant, and a bounded MFC wait with timeout.
module mem_port_arbiter #(
   parameter int TIMEOUT = 15,
   parameter int ADDR_W  = 8
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   input  logic              dm_req,
   input  logic              dm_rw,
   input  logic [1:0]        dm_size,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              dm_ack,
   output logic [31:0]       dm_rdata,
   output logic              dm_err,
   output logic              MFA,
   output logic              RW_RAM,
   output logic [1:0]        SIZE,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [31:0]       RAM_DIN,
   input  logic [31:0]       RAM_DOUT,
   input  logic              MFC,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [7:0] TERM = 8'(TIMEOUT - 1);

   state_t      state;
   logic        last_dm;
   logic        grant_dm;
   logic [7:0]  count;

   logic              pick_dm;
   logic              any_req;
   logic              sel_rw;
   logic [1:0]        sel_size;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic              legal;
   logic              issue;
   logic              resp_dm;
   logic              resp_err;
   logic [31:0]       resp_data;

   // Arbitration and legality are evaluated on the live inputs; they only
   // matter on the IDLE edge where the choice is latched.
   always_comb begin
      any_req   = if_req | dm_req;
      pick_dm   = dm_req & (~if_req | ~last_dm);
      sel_rw    = pick_dm ? dm_rw    : 1'b0;
      sel_size  = pick_dm ? dm_size  : 2'b10;
      sel_addr  = pick_dm ? dm_addr  : if_addr;
      sel_wdata = pick_dm ? dm_wdata : 32'h0;
      case (sel_size)
         2'b00:   legal = 1'b1;
         2'b01:   legal = ~sel_addr[0];
         2'b10:   legal = (sel_addr[1:0] == 2'b00);
         default: legal = 1'b0;
      endcase
   end

   // A response is issued either straight from IDLE (illegal access) or from
   // WAIT on MFC / terminal count. MFC beats the timeout on the same cycle.
   always_comb begin
      issue     = 1'b0;
      resp_dm   = grant_dm;
      resp_err  = 1'b0;
      resp_data = 32'h0;
      case (state)
         IDLE: begin
            issue    = any_req & ~legal;
            resp_dm  = pick_dm;
            resp_err = 1'b1;
         end
         WAIT: begin
            issue     = MFC | (count == TERM);
            resp_err  = ~MFC;
            resp_data = (MFC & ~RW_RAM) ? RAM_DOUT : 32'h0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state    <= IDLE;
         last_dm  <= 1'b1;
         grant_dm <= 1'b0;
         count    <= 8'd0;
         MFA      <= 1'b0;
         RW_RAM   <= 1'b0;
         SIZE     <= 2'b00;
         RAM_ADDR <= '0;
         RAM_DIN  <= 32'h0;
         if_ack   <= 1'b0;
         if_err   <= 1'b0;
         if_rdata <= 32'h0;
         dm_ack   <= 1'b0;
         dm_err   <= 1'b0;
         dm_rdata <= 32'h0;
         busy     <= 1'b0;
      end else begin
         if (issue) begin
            state <= RESP;
            MFA   <= 1'b0;
            if (resp_dm) begin
               dm_ack   <= 1'b1;
               dm_err   <= resp_err;
               dm_rdata <= resp_data;
            end else begin
               if_ack   <= 1'b1;
               if_err   <= resp_err;
               if_rdata <= resp_data;
            end
         end
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_dm <= pick_dm;
                  busy     <= 1'b1;
                  if (legal) begin
                     state    <= WAIT;
                     MFA      <= 1'b1;
                     RW_RAM   <= sel_rw;
                     SIZE     <= sel_size;
                     RAM_ADDR <= sel_addr;
                     RAM_DIN  <= sel_wdata;
                     count    <= 8'd0;
                  end
               end
            end
            WAIT: begin
               if (!issue) count <= count + 8'd1;
            end
            RESP: begin
               if_ack  <= 1'b0;
               dm_ack  <= 1'b0;
               last_dm <= grant_dm;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected responses,
// a negedge monitor pops them on every ack; a small RAM model answers MFA.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        Reset;
   logic        if_req;
   logic [7:0]  if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        dm_req;
   logic        dm_rw;
   logic [1:0]  dm_size;
   logic [7:0]  dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        dm_err;
   logic        MFA;
   logic        RW_RAM;
   logic [1:0]  SIZE;
   logic [7:0]  RAM_ADDR;
   logic [31:0] RAM_DIN;
   logic [31:0] RAM_DOUT;
   logic        MFC;
   logic        busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(15), .ADDR_W(8)) dut (
      .CLK(clk), .Reset(Reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
      .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
      .MFA(MFA), .RW_RAM(RW_RAM), .SIZE(SIZE), .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN),
      .RAM_DOUT(RAM_DOUT), .MFC(MFC), .busy(busy)
   );

   typedef struct {
      logic        dm;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // RAM model: MFC on the mfc_at-th consecutive MFA cycle (0 = never answer).
   int          mfc_at = 1;
   bit          use_fixed = 0;
   logic [31:0] fixed_dout = 32'h0;
   int          wcnt = 0;

   // MFA pulse bookkeeping from the monitor.
   int mfa_run = 0;
   int mfa_len = 0;
   int mfa_pulses = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   initial begin
      MFC = 1'b0;
      RAM_DOUT = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         wcnt = MFA ? wcnt + 1 : 0;
         MFC = MFA && (mfc_at != 0) && (wcnt == mfc_at);
         RAM_DOUT = use_fixed ? fixed_dout : {16'hC0DE, 8'h00, RAM_ADDR};
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (if_ack || dm_ack) begin
         chk("ack_exclusive", {31'h0, if_ack && dm_ack}, 32'h0);
         chk("mfa_low_during_ack", {31'h0, MFA}, 32'h0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got if_ack=%0b dm_ack=%0b expected none at %0t", if_ack, dm_ack, $time);
         end else begin
            e = exp_q.pop_front();
            $display("TXN port=%s rdata=%h err=%0b (expect port=%s rdata=%h err=%0b)",
                     dm_ack ? "DM" : "IF", dm_ack ? dm_rdata : if_rdata, dm_ack ? dm_err : if_err,
                     e.dm ? "DM" : "IF", e.data, e.err);
            chk("ack_port", {31'h0, dm_ack}, {31'h0, e.dm});
            chk("rdata", dm_ack ? dm_rdata : if_rdata, e.data);
            chk("err", {31'h0, dm_ack ? dm_err : if_err}, {31'h0, e.err});
         end
      end
      if (MFA) mfa_run++;
      else if (mfa_run > 0) begin
         mfa_len = mfa_run;
         mfa_run = 0;
         mfa_pulses++;
      end
   end

   task automatic push(input logic dm, input logic [31:0] data, input logic err);
      exp_t e;
      e.dm = dm; e.data = data; e.err = err;
      exp_q.push_back(e);
   endtask

   // Raise one request at a negedge, hold it until the arbiter goes busy,
   // then drop it and scramble the inputs (the latched copy must be used).
   task automatic issue(input bit dm, input bit rw, input logic [1:0] size,
                        input logic [7:0] addr, input logic [31:0] wdata);
      bit seen = 0;
      @(negedge clk);
      if (dm) begin
         dm_req = 1'b1; dm_rw = rw; dm_size = size; dm_addr = addr; dm_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = busy;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL grant_timeout: busy=0 expected 1 at %0t", $time);
      end
      if_req = 1'b0; dm_req = 1'b0;
      if_addr = 8'hEE; dm_addr = 8'hEE; dm_rw = ~dm_rw; dm_size = 2'b11; dm_wdata = 32'hDEADBEEF;
   endtask

   task automatic wait_done();
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && !busy;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL done_timeout: pending=%0d busy=%0b expected 0/0", exp_q.size(), busy);
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      Reset = 1'b1;
      repeat (2) @(negedge clk);
      Reset = 1'b0;
   endtask

   initial begin
      int p0;
      bit seen;
      Reset = 1'b1;
      if_req = 0; if_addr = 0; dm_req = 0; dm_rw = 0; dm_size = 0; dm_addr = 0; dm_wdata = 0;
      repeat (3) @(negedge clk);
      chk("rst_mfa", {31'h0, MFA}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_acks", {30'h0, if_ack, dm_ack}, 32'h0);
      chk("rst_errs", {30'h0, if_err, dm_err}, 32'h0);
      chk("rst_size_rw", {29'h0, SIZE, RW_RAM}, 32'h0);
      chk("rst_addr", {24'h0, RAM_ADDR}, 32'h0);
      chk("rst_din", RAM_DIN, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_dm_rdata", dm_rdata, 32'h0);
      Reset = 1'b0;

      // Single IF fetch, MFC on the first WAIT cycle.
      use_fixed = 1; fixed_dout = 32'hE3A01005; mfc_at = 1;
      push(1'b0, 32'hE3A01005, 1'b0);
      issue(1'b0, 1'b0, 2'b10, 8'h10, 32'h0);
      chk("if_mfa", {31'h0, MFA}, 32'h1);
      chk("if_size", {30'h0, SIZE}, 32'h2);
      chk("if_rw", {31'h0, RW_RAM}, 32'h0);
      chk("if_addr", {24'h0, RAM_ADDR}, 32'h10);
      wait_done();
      chk("if_mfa_len", mfa_len, 1);
      use_fixed = 0;

      // Tie after reset: IF first, then DM, both held.
      do_reset();
      p0 = mfa_pulses;
      push(1'b0, 32'hC0DE0014, 1'b0);
      push(1'b1, 32'hC0DE0020, 1'b0);
      @(negedge clk);
      if_req = 1; if_addr = 8'h14;
      dm_req = 1; dm_rw = 0; dm_size = 2'b10; dm_addr = 8'h20;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = dm_ack;
      end
      if_req = 0; dm_req = 0;
      wait_done();
      chk("tie_two_pulses", mfa_pulses - p0, 2);

      // Illegal accesses: never touch the RAM.
      p0 = mfa_pulses;
      push(1'b1, 32'h0, 1'b1);
      issue(1'b1, 1'b1, 2'b10, 8'h22, 32'h11111111);
      wait_done();
      push(1'b1, 32'h0, 1'b1);
      issue(1'b1, 1'b0, 2'b01, 8'h05, 32'h0);
      wait_done();
      push(1'b1, 32'h0, 1'b1);
      issue(1'b1, 1'b0, 2'b11, 8'h04, 32'h0);
      wait_done();
      chk("illegal_no_mfa", mfa_pulses - p0, 0);

      // Timeout: MFC never comes.
      mfc_at = 0;
      push(1'b1, 32'h0, 1'b1);
      issue(1'b1, 1'b0, 2'b00, 8'h05, 32'h0);
      wait_done();
      chk("timeout_mfa_len", mfa_len, 15);

      // MFC on the terminal WAIT cycle wins.
      mfc_at = 15;
      push(1'b1, 32'hC0DE0005, 1'b0);
      issue(1'b1, 1'b0, 2'b00, 8'h05, 32'h0);
      wait_done();
      chk("terminal_mfa_len", mfa_len, 15);

      // Word write: latched write data on the RAM port, rdata returns 0.
      mfc_at = 2;
      push(1'b1, 32'h0, 1'b0);
      issue(1'b1, 1'b1, 2'b10, 8'h40, 32'h12345678);
      chk("wr_din", RAM_DIN, 32'h12345678);
      chk("wr_rw", {31'h0, RW_RAM}, 32'h1);
      chk("wr_addr", {24'h0, RAM_ADDR}, 32'h40);
      @(negedge clk);
      chk("wr_din_stable", RAM_DIN, 32'h12345678);
      wait_done();
      chk("wr_mfa_len", mfa_len, 2);

      // Reset on the third WAIT cycle abandons the fetch.
      mfc_at = 0;
      issue(1'b0, 1'b0, 2'b10, 8'h30, 32'h0);
      repeat (2) @(negedge clk);
      Reset = 1'b1;
      @(negedge clk);
      chk("abort_mfa", {31'h0, MFA}, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_ack", {30'h0, if_ack, dm_ack}, 32'h0);
      Reset = 1'b0;
      repeat (3) @(negedge clk);
      mfc_at = 1;
      push(1'b1, 32'hC0DE0008, 1'b0);
      issue(1'b1, 1'b0, 2'b00, 8'h08, 32'h0);
      wait_done();

      // Reset restored last_grant=DM, so IF wins this tie.
      push(1'b0, 32'hC0DE000C, 1'b0);
      push(1'b1, 32'hC0DE001C, 1'b0);
      @(negedge clk);
      if_req = 1; if_addr = 8'h0C;
      dm_req = 1; dm_rw = 0; dm_size = 2'b10; dm_addr = 8'h1C;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = dm_ack;
      end
      if_req = 0; dm_req = 0;
      wait_done();

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles MFA is held awaiting MFC (legal range 1..255).
REQ-002 Parameter ADDR_W, default 8: RAM byte-address width.
REQ-003 CLK  in  1  system clock; all state changes on the rising edge; single clock domain.
REQ-004 Reset  in  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-005 if_req  in  1  instruction-fetch request (read, word size).
REQ-006 if_addr  in  ADDR_W  fetch byte address.
REQ-007 if_ack  out  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  out  32  fetch data, valid while if_ack=1.
REQ-009 if_err  out  1  fetch error, valid while if_ack=1.
REQ-010 dm_req  in  1  data-memory request.
REQ-011 dm_rw  in  1  1 = write, 0 = read.
REQ-012 dm_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-013 dm_addr  in  ADDR_W  data byte address.
REQ-014 dm_wdata  in  32  write data.
REQ-015 dm_ack, dm_rdata[31:0], dm_err  out  1/32/1  same semantics as the if_* responses.
REQ-016 MFA  out  1  memory function active, to RAM.
REQ-017 RW_RAM  out  1  1 = write, to RAM.
REQ-018 SIZE  out  2  access size, to RAM.
REQ-019 RAM_ADDR  out  ADDR_W; RAM_DIN  out  32  write data; RAM_DOUT  in  32  read data.
REQ-020 MFC  in  1  memory function complete, from RAM.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 FSM states SHALL be IDLE, WAIT and RESP; all outputs SHALL be registered.
REQ-023 IDLE, no request: remain in IDLE with MFA=0.
REQ-024 IDLE, exactly one request: grant that port.
REQ-025 IDLE, both requests: grant the port not granted last (round-robin); last_grant updates only when a response is issued in RESP.
REQ-026 On grant, address, rw, size and wdata SHALL be latched; IF grants use rw=0 and size=10. Later input changes SHALL be ignored until the port's ack.
REQ-027 Legality check at grant: size=11 is illegal; word with addr[1:0]!=0 is illegal; halfword with addr[0]!=0 is illegal.
REQ-028 Illegal grant: go directly to RESP with err=1; MFA SHALL never assert.
REQ-029 Legal grant: go to WAIT and clear the timeout counter.
REQ-030 WAIT: MFA=1 and RAM_ADDR, RW_RAM, SIZE, RAM_DIN driven from the latched values, stable for the whole state.
REQ-031 WAIT, MFC=1 sampled: capture RAM_DOUT and go to RESP with err=0.
REQ-032 WAIT, MFC=0: increment the counter; at count TIMEOUT-1 go to RESP with err=1 and rdata=0.
REQ-033 MFC=1 on the terminal count cycle is a success (MFC wins over timeout).
REQ-034 Consequence: MFA SHALL be high for at most TIMEOUT consecutive cycles.
REQ-035 RESP: MFA=0; granted port's ack=1 for exactly one cycle with rdata and err valid; the other port's ack stays 0; next state IDLE.
REQ-036 Writes return rdata=0.
REQ-037 A request dropped before its ack still completes; the ack is still pulsed.
REQ-038 Minimum latency: request sampled in IDLE at edge k -> MFA=1 from edge k+1 -> ack at edge k+2 if MFC=1 in the first WAIT cycle; re-arbitration at k+3.
REQ-039 MFC asserted outside WAIT SHALL be ignored.

Reset
REQ-040 Reset=1 at an edge: state IDLE; MFA, RW_RAM, acks, errs and busy = 0; SIZE=00; RAM_ADDR, RAM_DIN and both rdata = 0; counter = 0; last_grant = DM, so IF wins the first tie.
REQ-041 Reset during WAIT or RESP abandons the transaction: MFA low after that edge and no ack issued.
REQ-042 Reset has priority over every other event in the same cycle.

Verification
REQ-043 if_req=1, if_addr=0x10, MFC=1 one cycle after MFA rises, RAM_DOUT=0xE3A01005 -> if_ack pulses once with if_rdata=0xE3A01005, if_err=0, SIZE=10, RW_RAM=0.
REQ-044 Both ports request after reset, held through two accesses -> IF granted first, then DM; dm_ack follows if_ack, with MFA low for at least one cycle between accesses.
REQ-045 dm_req write, size=10, addr=0x22 -> dm_ack with dm_err=1; MFA never rises.
REQ-046 dm read, size=00, addr=0x05, MFC held low, TIMEOUT=15 -> MFA high for exactly 15 cycles, then dm_ack with dm_err=1 and dm_rdata=0.
REQ-047 MFC rises on the 15th WAIT cycle -> success, dm_err=0.
REQ-048 Reset asserted on the 3rd WAIT cycle -> MFA=0 next cycle, no ack, busy=0; the next request is granted normally.
